// File: rtl/fifo_nibble_packer_if.sv
// Handshake bundle for the nibble packer: FIFO drain side plus the packed-word
// valid/ready side. The packer uses the master modport, its environment the slave.
interface fifo_nibble_packer_if #(
  parameter int MSBD = 3,
  parameter int NUM  = 4
);
  logic [MSBD:0]                fifoData;
  logic                         fifoEmpty;
  logic                         fifoPop;
  logic                         flush;
  logic [NUM*(MSBD+1)-1:0]      wordOut;
  logic [3:0]                   wordLen;
  logic                         wordValid;
  logic                         wordReady;

  modport master (
    input  fifoData, fifoEmpty, flush, wordReady,
    output fifoPop, wordOut, wordLen, wordValid
  );

  modport slave (
    output fifoData, fifoEmpty, flush, wordReady,
    input  fifoPop, wordOut, wordLen, wordValid
  );
endinterface

// File: rtl/fifo_nibble_packer.sv
// Drains nibbles from the ring-buffer FIFO and packs NUM of them (first popped in
// the LSBs) into a registered valid/ready word; flush emits a zero-padded partial word.
module fifo_nibble_packer #(
  parameter int MSBD = 3,
  parameter int NUM  = 4
) (
  input  logic                  clock,
  input  logic                  resetN,
  fifo_nibble_packer_if.master  bus
);
  localparam int W  = MSBD + 1;
  localparam int WW = NUM * W;
  localparam int AW = (NUM - 1) * W;

  logic [AW-1:0] acc_r;
  logic [3:0]    count_r;
  logic          flush_pend_r;
  logic [WW-1:0] word_out_r;
  logic [3:0]    word_len_r;
  logic          word_valid_r;

  logic          slot_free_s;
  logic          flush_act_s;
  logic          pop_s;
  logic          emit_s;
  logic [3:0]    new_count_s;
  logic [WW-1:0] acc_ext_s;
  logic [WW-1:0] working_s;

  // Pop decision, working word and emit decision for the current cycle.
  always_comb begin
    slot_free_s = ~word_valid_r | bus.wordReady;
    flush_act_s = bus.flush | flush_pend_r;
    // Under back-pressure (or a pending flush) stop once acc holds NUM-1 nibbles.
    pop_s = resetN & ~bus.fifoEmpty &
            (slot_free_s | ((count_r < 4'(NUM - 1)) & ~flush_act_s));
    new_count_s = pop_s ? (count_r + 4'd1) : count_r;
    acc_ext_s = {{W{1'b0}}, acc_r};
    working_s = '0;
    for (int i = 0; i < NUM; i++) begin
      working_s[i*W +: W] = (pop_s && (count_r == 4'(i))) ? bus.fifoData :
                            ((4'(i) < new_count_s) ? acc_ext_s[i*W +: W] : {W{1'b0}});
    end
    emit_s = slot_free_s &
             ((new_count_s == 4'(NUM)) | (flush_act_s & (new_count_s != 4'd0)));
  end

  // Accumulator, sticky flush flag and the registered output word.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      acc_r        <= '0;
      count_r      <= 4'd0;
      flush_pend_r <= 1'b0;
      word_out_r   <= '0;
      word_len_r   <= 4'd0;
      word_valid_r <= 1'b0;
    end else if (emit_s) begin
      word_out_r   <= working_s;
      word_len_r   <= new_count_s;
      word_valid_r <= 1'b1;
      acc_r        <= '0;
      count_r      <= 4'd0;
      flush_pend_r <= 1'b0;
    end else begin
      // Without an emit newCount stays below NUM, so the top nibble is always zero.
      acc_r   <= working_s[AW-1:0];
      count_r <= new_count_s;
      if (bus.wordReady) begin
        word_valid_r <= 1'b0;
      end else begin
        word_valid_r <= word_valid_r;
      end
      if (flush_act_s && (new_count_s != 4'd0)) begin
        flush_pend_r <= 1'b1;
      end else if (flush_act_s) begin
        flush_pend_r <= 1'b0;
      end else begin
        flush_pend_r <= flush_pend_r;
      end
    end
  end

  assign bus.fifoPop   = pop_s;
  assign bus.wordOut   = word_out_r;
  assign bus.wordLen   = word_len_r;
  assign bus.wordValid = word_valid_r;
endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Self-checking bench: a queue-based FIFO feeds the packer and every accepted word
// is compared against the in-order stream of pushed nibbles.
module tb_fifo_nibble_packer;
  localparam int MSBD = 3;
  localparam int NUM  = 4;
  localparam int W    = MSBD + 1;
  localparam int WW   = NUM * W;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  fifo_nibble_packer_if #(.MSBD(MSBD), .NUM(NUM)) bus ();
  fifo_nibble_packer #(.MSBD(MSBD), .NUM(NUM)) dut (.clock(clock), .resetN(resetN), .bus(bus.master));

  int checks = 0;
  int failures = 0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int word_cycs[$];
  int cyc = 0, pops = 0, words = 0, valid_cycles = 0, first_pop_cyc = 0, last_pop_cyc = 0;
  bit allow_partial = 1'b0;
  logic s_pop, s_valid, s_ready, prev_valid, prev_ready;
  logic [WW-1:0] s_out, prev_out, last_out;
  logic [3:0] s_len, prev_len, last_len;

  task automatic drive_fifo();
    bus.fifoEmpty = (fifo_q.size() == 0);
    bus.fifoData  = (fifo_q.size() == 0) ? 4'h0 : fifo_q[0];
  endtask

  task automatic push(input logic [W-1:0] nib);
    fifo_q.push_back(nib);
    exp_q.push_back(nib);
  endtask

  task automatic clear_stats();
    pops = 0; words = 0; valid_cycles = 0; word_cycs.delete();
  endtask

  // One clock cycle: sample pre-edge, check protocol and accepted words, then advance the FIFO.
  task automatic tick();
    logic [W-1:0] nib, e;
    drive_fifo();
    @(negedge clock);
    s_pop = bus.fifoPop; s_valid = bus.wordValid; s_ready = bus.wordReady;
    s_out = bus.wordOut; s_len = bus.wordLen;
    cyc++;
    checks++;
    if (s_pop && bus.fifoEmpty) begin
      failures++; $display("FAIL pop_while_empty cyc=%0d got=1 want=0", cyc);
    end
    if (prev_valid && !prev_ready) begin
      checks++;
      if (s_valid !== 1'b1 || s_out !== prev_out || s_len !== prev_len) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got v=%b out=%h len=%0d want v=1 out=%h len=%0d",
                 cyc, s_valid, s_out, s_len, prev_out, prev_len);
      end
    end
    if (s_valid) valid_cycles++;
    if (s_valid && s_ready) begin
      words++; word_cycs.push_back(cyc); last_out = s_out; last_len = s_len;
      checks++;
      if (s_len == 4'd0 || s_len > 4'(NUM) || (!allow_partial && s_len != 4'(NUM))) begin
        failures++; $display("FAIL word_len cyc=%0d got=%0d partial_ok=%0d", cyc, s_len, allow_partial);
      end
      for (int i = 0; i < NUM; i++) begin
        nib = s_out[i*W +: W];
        checks++;
        if (i < int'(s_len)) begin
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL extra_nibble cyc=%0d pos=%0d got=%h want=none", cyc, i, nib);
          end else begin
            e = exp_q.pop_front();
            if (nib !== e) begin
              failures++; $display("FAIL nibble_order cyc=%0d pos=%0d got=%h want=%h", cyc, i, nib, e);
            end
          end
        end else if (nib !== 4'h0) begin
          failures++; $display("FAIL zero_pad cyc=%0d pos=%0d got=%h want=0", cyc, i, nib);
        end
      end
    end
    if (s_pop) begin
      if (pops == 0) first_pop_cyc = cyc;
      pops++; last_pop_cyc = cyc;
    end
    prev_valid = s_valid; prev_ready = s_ready; prev_out = s_out; prev_len = s_len;
    @(posedge clock); #1;
    if (s_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic test_reset();
    resetN = 1'b0; bus.flush = 1'b0; bus.wordReady = 1'b1;
    prev_valid = 1'b0; prev_ready = 1'b0;
    fifo_q.push_back(4'h7);
    drive_fifo();
    repeat (2) begin
      @(negedge clock);
      checks++;
      if (bus.fifoPop !== 1'b0 || bus.wordValid !== 1'b0 || bus.wordOut !== 16'h0 || bus.wordLen !== 4'd0) begin
        failures++;
        $display("FAIL reset_state got pop=%b v=%b out=%h len=%0d want 0 0 0000 0",
                 bus.fifoPop, bus.wordValid, bus.wordOut, bus.wordLen);
      end
    end
    fifo_q.delete(); drive_fifo();
    @(posedge clock); #1; resetN = 1'b1;
    clear_stats();
    repeat (4) tick();
    checks++;
    if (pops != 0 || valid_cycles != 0 || s_out !== 16'h0 || s_len !== 4'd0) begin
      failures++; $display("FAIL idle_after_reset got pops=%0d valid=%0d out=%h len=%0d want 0 0 0000 0",
                           pops, valid_cycles, s_out, s_len);
    end
  endtask

  task automatic test_full_word();
    clear_stats(); allow_partial = 1'b0; bus.wordReady = 1'b1;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    repeat (8) tick();
    checks++;
    if (pops != 4 || last_pop_cyc - first_pop_cyc != 3) begin
      failures++; $display("FAIL full_pops got=%0d span=%0d want=4 span=3", pops, last_pop_cyc - first_pop_cyc);
    end
    checks++;
    if (words != 1 || valid_cycles != 1 || last_out !== 16'h4321 || last_len !== 4'd4) begin
      failures++; $display("FAIL full_word got words=%0d vcyc=%0d out=%h len=%0d want 1 1 4321 4",
                           words, valid_cycles, last_out, last_len);
    end
    checks++;
    if (words == 1 && word_cycs[0] - last_pop_cyc != 1) begin
      failures++; $display("FAIL full_latency got=%0d want=1", word_cycs[0] - last_pop_cyc);
    end
  endtask

  task automatic test_flush_partial();
    clear_stats(); allow_partial = 1'b1; bus.wordReady = 1'b1;
    push(4'hA); push(4'hB);
    repeat (4) tick();
    checks++;
    if (pops != 2 || words != 0) begin
      failures++; $display("FAIL partial_hold got pops=%0d words=%0d want 2 0", pops, words);
    end
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    repeat (3) tick();
    checks++;
    if (words != 1 || last_out !== 16'h00BA || last_len !== 4'd2) begin
      failures++; $display("FAIL flush_partial got words=%0d out=%h len=%0d want 1 00ba 2", words, last_out, last_len);
    end
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    repeat (4) tick();
    checks++;
    if (words != 1 || valid_cycles != 1) begin
      failures++; $display("FAIL flush_empty got words=%0d vcyc=%0d want 1 1", words, valid_cycles);
    end
  endtask

  task automatic test_flush_with_pop();
    clear_stats(); allow_partial = 1'b1; bus.wordReady = 1'b1;
    push(4'h5);
    repeat (2) tick();
    push(4'h6); bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    checks++;
    if (s_pop !== 1'b1 || pops != 2) begin
      failures++; $display("FAIL flush_pop_cycle got pop=%b pops=%0d want 1 2", s_pop, pops);
    end
    repeat (2) tick();
    checks++;
    if (words != 1 || last_out !== 16'h0065 || last_len !== 4'd2) begin
      failures++; $display("FAIL flush_with_pop got words=%0d out=%h len=%0d want 1 0065 2", words, last_out, last_len);
    end
    allow_partial = 1'b0;
    push(4'h7);
    repeat (4) tick();
    checks++;
    if (words != 1) begin
      failures++; $display("FAIL flush_pend_cleared got words=%0d want 1", words);
    end
    push(4'h8); push(4'h9); push(4'hA);
    repeat (5) tick();
    checks++;
    if (words != 2 || last_out !== 16'hA987 || last_len !== 4'd4) begin
      failures++; $display("FAIL after_flush_word got words=%0d out=%h len=%0d want 2 a987 4", words, last_out, last_len);
    end
  endtask

  task automatic test_back_pressure();
    clear_stats(); allow_partial = 1'b0; bus.wordReady = 1'b0;
    for (int i = 0; i < 10; i++) push(4'($urandom));
    repeat (12) tick();
    checks++;
    if (pops != 7 || s_pop !== 1'b0 || s_valid !== 1'b1 || words != 0) begin
      failures++; $display("FAIL bp_stall got pops=%0d pop=%b v=%b words=%0d want 7 0 1 0", pops, s_pop, s_valid, words);
    end
    bus.wordReady = 1'b1; tick();
    checks++;
    if (s_pop !== 1'b1) begin
      failures++; $display("FAIL bp_resume got pop=%b want 1", s_pop);
    end
    repeat (8) tick();
    checks++;
    if (pops != 10 || words != 2) begin
      failures++; $display("FAIL bp_drain got pops=%0d words=%0d want 10 2", pops, words);
    end
    allow_partial = 1'b1; bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    repeat (3) tick();
    checks++;
    if (words != 3 || last_len !== 4'd2 || exp_q.size() != 0) begin
      failures++; $display("FAIL bp_tail got words=%0d len=%0d left=%0d want 3 2 0", words, last_len, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_stats(); allow_partial = 1'b0; bus.wordReady = 1'b1;
    for (int i = 0; i < 12; i++) push(4'($urandom));
    repeat (16) tick();
    checks++;
    if (pops != 12 || last_pop_cyc - first_pop_cyc != 11) begin
      failures++; $display("FAIL b2b_pops got=%0d span=%0d want 12 11", pops, last_pop_cyc - first_pop_cyc);
    end
    checks++;
    if (words != 3) begin
      failures++; $display("FAIL b2b_words got=%0d want=3", words);
    end else if (word_cycs[1] - word_cycs[0] != 4 || word_cycs[2] - word_cycs[1] != 4) begin
      failures++; $display("FAIL b2b_spacing got=%0d,%0d want=4,4",
                           word_cycs[1] - word_cycs[0], word_cycs[2] - word_cycs[1]);
    end
  endtask

  task automatic test_async_reset();
    clear_stats(); allow_partial = 1'b0; bus.wordReady = 1'b0;
    for (int i = 0; i < 6; i++) push(4'($urandom));
    repeat (10) tick();
    checks++;
    if (s_valid !== 1'b1 || pops != 6) begin
      failures++; $display("FAIL ar_setup got v=%b pops=%0d want 1 6", s_valid, pops);
    end
    #2 resetN = 1'b0;
    #1;
    checks++;
    if (bus.wordValid !== 1'b0 || bus.wordOut !== 16'h0 || bus.wordLen !== 4'd0) begin
      failures++; $display("FAIL ar_immediate got v=%b out=%h len=%0d want 0 0000 0", bus.wordValid, bus.wordOut, bus.wordLen);
    end
    fifo_q.delete(); exp_q.delete(); prev_valid = 1'b0; prev_ready = 1'b0; drive_fifo();
    @(posedge clock); #1; resetN = 1'b1;
    clear_stats(); bus.wordReady = 1'b1;
    for (int i = 0; i < 4; i++) push(4'($urandom));
    repeat (7) tick();
    checks++;
    if (words != 1 || last_len !== 4'd4 || exp_q.size() != 0) begin
      failures++; $display("FAIL ar_clean_word got words=%0d len=%0d left=%0d want 1 4 0", words, last_len, exp_q.size());
    end
  endtask

  task automatic test_random();
    int guard;
    clear_stats(); allow_partial = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 60 && fifo_q.size() < 16) push(4'($urandom));
      bus.wordReady = ($urandom_range(0, 99) < 70);
      bus.flush     = ($urandom_range(0, 99) < 5);
      tick();
    end
    bus.wordReady = 1'b1; bus.flush = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      tick(); guard++;
    end
    bus.flush = 1'b0;
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0 || fifo_q.size() != 0) begin
      failures++; $display("FAIL random_drain got left=%0d fifo=%0d want 0 0", exp_q.size(), fifo_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush_partial();
    test_flush_with_pop();
    test_back_pressure();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_nibble_packer.md
# fifo_nibble_packer

Downstream drain stage for the 4-bit ring-buffer FIFO. Pops nibbles through the FIFO's `pop`/`empty`/`dataOut` interface and packs NUM consecutive nibbles, first-popped in the least-significant position, into one wide word. Presents each word on a registered valid/ready output. A flush request emits a zero-padded partial word, so a trailing fragment never stays stranded in the packer.

## Interface
- MSBD, 3: MSB index of a FIFO data nibble; nibble width W = MSBD+1.
- NUM, 4: nibbles per output word (2..8); word width NUM*W.
- clock  input  1  sole clock; all state updates on posedge.
- resetN  input  1  asynchronous, active-low reset. Asserts immediately; deasserts synchronously to clock externally.
- fifoData  input  W  FIFO head data (`dataOut`), combinational from FIFO, valid when fifoEmpty=0.
- fifoEmpty  input  1  FIFO `empty` flag.
- fifoPop  output  1  FIFO `pop`. Combinational; the FIFO consumes on the same posedge.
- flush  input  1  one-cycle or level request to emit the pending partial word.
- wordOut  output  NUM*W  packed word, registered.
- wordLen  output  4  count of valid nibbles in wordOut (1..NUM), registered.
- wordValid  output  1  output word valid, registered.
- wordReady  input  1  downstream accepts wordOut when wordValid=1 at posedge.

## Operation
- State:
  - acc: (NUM-1)*W accumulator.
  - count: 0..NUM-1, nibbles held in acc.
  - flushPend: sticky flush flag.
  - Output register: wordOut, wordLen, wordValid.
- Derived signals:
  - slotFree = ~wordValid | wordReady.
  - flushAct = flush | flushPend.
- fifoPop = resetN & ~fifoEmpty & (slotFree | (count < NUM-1 & ~flushAct)).
- On pop, the nibble goes to position count of a working value; newCount = count+1. Without pop, newCount = count.
- Emit when slotFree & (newCount == NUM | (flushAct & newCount > 0)):
  - wordOut = working value, with nibble positions ≥ newCount zeroed.
  - wordLen = newCount; wordValid = 1.
  - acc = 0; count = 0; flushPend = 0.
- No emit:
  - acc/count take the working value and newCount.
  - wordValid clears if wordReady was high; otherwise wordOut, wordLen and wordValid hold stable.
- flushPend:
  - Set when flushAct and no emit occurred and newCount > 0.
  - Cleared when flushAct and newCount == 0. A flush on an empty packer is a no-op.
- A flush arriving with a pop in the same cycle includes the popped nibble in the flushed word.
- Back-pressure: when wordValid=1 and wordReady=0, the packer keeps popping until acc holds NUM-1 nibbles, then stalls with fifoPop=0. It never drops or overwrites a nibble.
- A flush pending under back-pressure also stops popping and emits exactly when the slot frees.
- The packer never pops while fifoEmpty=1.

## Timing
- Reset values: acc=0, count=0, flushPend=0, wordOut=0, wordLen=0, wordValid=0.
- fifoPop is 0 throughout reset.
- Reset mid-word discards the partial nibbles without any output.
- Latency: the posedge that pops the NUM-th nibble (or accepts flushAct) makes wordValid=1 in the following cycle.
- Throughput:
  - Continuous FIFO data with wordReady=1 gives one pop per cycle and one word every NUM cycles.
  - Back-to-back words with no bubble: a word is emitted in the same cycle the previous one is accepted.
- Output handshake: wordOut and wordLen are stable while wordValid=1 and wordReady=0. wordValid deasserts only after acceptance.
- The path fifoEmpty → fifoPop is combinational. The FIFO's empty is registered, so no combinational loop exists.

## Test plan
- Reset then idle: after resetN rises with fifoEmpty=1, wordValid=0, wordOut=0, wordLen=0, and fifoPop stays 0.
- Full word: FIFO holds 1,2,3,4 and wordReady=1:
  - Four consecutive pops.
  - One cycle after the 4th pop: wordOut=16'h4321, wordLen=4, wordValid=1 for 1 cycle.
- Flush partial: push A,B then pulse flush (no simultaneous pop) → wordOut=16'h00BA, wordLen=2. Flush with count=0 produces nothing.
- Flush with simultaneous pop: count=1 (nibble 5), FIFO head 6, flush high on the pop cycle → wordOut=16'h0065, wordLen=2. flushPend is 0 afterwards.
- Back-pressure: wordReady=0 with 10 nibbles queued:
  - First word held stable.
  - Packer pops exactly 3 more nibbles, then fifoPop=0.
  - Raising wordReady resumes popping. All 10 nibbles emerge in order, last word wordLen=... only after flush (2 nibbles, wordLen=2).
- Async reset mid-word: assert resetN low with count=2 and wordValid=1 → wordValid drops immediately, without a clock edge. After release, the next 4 nibbles form a clean word with no stale data.
